uv_sample_scheduler: RTL and testbench

- Sequences the I2C UV-sensor transaction engine through its start/ready handshake.
- Merges periodic sampling ticks with on-demand CPU requests into single transactions.
- Captures each 16-bit result and maintains a power-of-two moving average.
- Sits between the J1 SoC peripheral registers and the sensor engine; flags timeouts and overruns for firmware.

---
 rtl/uv_pkg.sv | 17 +
 rtl/uv_moving_avg.sv | 68 ++++++
 rtl/uv_sample_scheduler.sv | 174 +++++++++++++++++
 tb/tb_uv_sample_scheduler.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uv_pkg.sv
// Shared types and defaults for the UV sensor sample scheduler.
// Holds the FSM state encoding and default timing constants.
package uv_pkg;

  localparam int UV_DW             = 16;
  localparam int UV_PERIOD_CYCLES  = 50_000_000;
  localparam int UV_TIMEOUT_CYCLES = 1_000_000;
  localparam int UV_AVG_LOG2       = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_WAIT_DONE,
    ST_CAPTURE
  } uv_state_e;

endpackage

// File: rtl/uv_moving_avg.sv
// Power-of-two moving average over the last 2^AVG_LOG2 samples.
// Ports: clk, rst (async active-low), push + din in, avg out.
module uv_moving_avg
  import uv_pkg::*;
#(
  parameter int DW       = UV_DW,
  parameter int AVG_LOG2 = UV_AVG_LOG2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] avg
);

  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int PW    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int SW    = DW + AVG_LOG2;

  logic [DEPTH-1:0][DW-1:0] ring_q, ring_d;
  logic [PW-1:0]            ptr_q, ptr_d;
  logic [PW-1:0]            ptr_nxt;
  logic [SW-1:0]            sum_q, sum_d;
  logic                     filled_q, filled_d;

  assign ptr_nxt = (ptr_q == PW'(DEPTH - 1))
                 ? '0 : ptr_q + PW'(1);

  always_comb begin
    ring_d   = ring_q;
    ptr_d    = ptr_q;
    sum_d    = sum_q;
    filled_d = filled_q;
    if (push) begin
      if (!filled_q) begin
        // First sample fills the whole window so
        // the average starts out equal to it.
        for (int i = 0; i < DEPTH; i++) begin
          ring_d[i] = din;
        end
        sum_d    = SW'(din) << AVG_LOG2;
        filled_d = 1'b1;
      end else begin
        ring_d[ptr_q] = din;
        sum_d = sum_q - SW'(ring_q[ptr_q])
              + SW'(din);
      end
      ptr_d = ptr_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ring_q   <= '0;
      ptr_q    <= '0;
      sum_q    <= '0;
      filled_q <= 1'b0;
    end else begin
      ring_q   <= ring_d;
      ptr_q    <= ptr_d;
      sum_q    <= sum_d;
      filled_q <= filled_d;
    end
  end

  assign avg = sum_q[SW-1:AVG_LOG2];

endmodule

// File: rtl/uv_sample_scheduler.sv
// UV sensor sample scheduler: merges periodic ticks and CPU
// one-shots, drives the engine start/ready handshake, captures
// results into sample/avg/sample_count and flags timeout/overrun.
// Ports: clk, rst (async active-low), enable, one_shot, clr_err,
// eng_start/eng_ready/eng_data, sample, avg, sample_valid, busy,
// timeout_err, overrun, sample_count.
module uv_sample_scheduler
  import uv_pkg::*;
#(
  parameter int PERIOD_CYCLES  = UV_PERIOD_CYCLES,
  parameter int TIMEOUT_CYCLES = UV_TIMEOUT_CYCLES,
  parameter int AVG_LOG2       = UV_AVG_LOG2,
  parameter int DW             = UV_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic          one_shot,
  input  logic          clr_err,
  output logic          eng_start,
  input  logic          eng_ready,
  input  logic [DW-1:0] eng_data,
  output logic [DW-1:0] sample,
  output logic [DW-1:0] avg,
  output logic          sample_valid,
  output logic          busy,
  output logic          timeout_err,
  output logic          overrun,
  output logic [7:0]    sample_count
);

  localparam int PCW = (PERIOD_CYCLES > 2)
                     ? $clog2(PERIOD_CYCLES) : 1;
  localparam int TCW = (TIMEOUT_CYCLES > 2)
                     ? $clog2(TIMEOUT_CYCLES) : 1;

  uv_state_e      state_q, state_d;
  logic [PCW-1:0] period_cnt_q, period_cnt_d;
  logic [TCW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic           pending_q, pending_d;
  logic           timeout_err_q, timeout_err_d;
  logic           overrun_q, overrun_d;
  logic [DW-1:0]  sample_q, sample_d;
  logic           sample_valid_q, sample_valid_d;
  logic [7:0]     sample_count_q, sample_count_d;

  logic tick;
  logic trig;
  logic consume;
  logic capture;
  logic tmo_hit;
  logic tmo_fire;
  logic tmo_active;
  logic overrun_set;

  always_comb begin
    tick = enable &&
      (period_cnt_q == PCW'(PERIOD_CYCLES - 1));
    if (!enable || tick) begin
      period_cnt_d = '0;
    end else begin
      period_cnt_d = period_cnt_q + PCW'(1);
    end
  end

  always_comb begin
    state_d  = state_q;
    tmo_fire = 1'b0;
    capture  = 1'b0;
    tmo_hit  = (tmo_cnt_q == TCW'(TIMEOUT_CYCLES - 1));
    unique case (state_q)
      ST_IDLE: begin
        if (pending_q) state_d = ST_ARM;
      end
      ST_ARM: begin
        if (!eng_ready) begin
          state_d = ST_WAIT_DONE;
        end else if (tmo_hit) begin
          tmo_fire = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      ST_WAIT_DONE: begin
        if (eng_ready) begin
          state_d = ST_CAPTURE;
        end else if (tmo_hit) begin
          tmo_fire = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      ST_CAPTURE: begin
        capture = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    tmo_active = (state_q == ST_ARM) ||
                 (state_q == ST_WAIT_DONE);
    if (!tmo_active || state_d != state_q) begin
      tmo_cnt_d = '0;
    end else begin
      tmo_cnt_d = tmo_cnt_q + TCW'(1);
    end
  end

  always_comb begin
    consume     = (state_q == ST_IDLE) && pending_q;
    trig        = tick | one_shot;
    pending_d   = pending_q & ~consume;
    overrun_set = 1'b0;
    // A trigger landing as IDLE takes the pending one
    // is kept, not lost.
    if (trig) begin
      if (pending_q && !consume) begin
        overrun_set = 1'b1;
      end else begin
        pending_d = 1'b1;
      end
    end
    overrun_d     = (overrun_q & ~clr_err) | overrun_set;
    timeout_err_d = (timeout_err_q & ~clr_err) | tmo_fire;
    sample_d       = capture ? eng_data : sample_q;
    sample_valid_d = capture;
    sample_count_d = capture ? sample_count_q + 8'd1
                             : sample_count_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      period_cnt_q   <= '0;
      tmo_cnt_q      <= '0;
      pending_q      <= 1'b0;
      timeout_err_q  <= 1'b0;
      overrun_q      <= 1'b0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
      sample_count_q <= '0;
    end else begin
      state_q        <= state_d;
      period_cnt_q   <= period_cnt_d;
      tmo_cnt_q      <= tmo_cnt_d;
      pending_q      <= pending_d;
      timeout_err_q  <= timeout_err_d;
      overrun_q      <= overrun_d;
      sample_q       <= sample_d;
      sample_valid_q <= sample_valid_d;
      sample_count_q <= sample_count_d;
    end
  end

  uv_moving_avg #(
    .DW       (DW),
    .AVG_LOG2 (AVG_LOG2)
  ) u_avg (
    .clk  (clk),
    .rst  (rst),
    .push (capture),
    .din  (eng_data),
    .avg  (avg)
  );

  assign eng_start    = (state_q == ST_ARM);
  assign busy         = (state_q != ST_IDLE);
  assign sample       = sample_q;
  assign sample_valid = sample_valid_q;
  assign timeout_err  = timeout_err_q;
  assign overrun      = overrun_q;
  assign sample_count = sample_count_q;

endmodule

// File: tb/tb_uv_sample_scheduler.sv
// Bench for uv_sample_scheduler: engine model plus a scoreboard
// of expected captures fed from a table of sample vectors.
module tb_uv_sample_scheduler;

  localparam int DW = 16;

  typedef struct {
    logic [15:0] data;
    logic [15:0] avg;
    logic [7:0]  cnt;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          one_shot = 1'b0;
  logic          clr_err = 1'b0;
  logic          eng_ready = 1'b1;
  logic [DW-1:0] eng_data = '0;
  logic          eng_start;
  logic [DW-1:0] sample;
  logic [DW-1:0] avg;
  logic          sample_valid;
  logic          busy;
  logic          timeout_err;
  logic          overrun;
  logic [7:0]    sample_count;

  vec_t        vec [10];
  vec_t        exp_q [$];
  logic [15:0] data_q [$];
  int          valid_cyc [$];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          rise_cyc = 0;
  bit          eng_respond = 1'b1;

  uv_sample_scheduler #(
    .PERIOD_CYCLES  (100),
    .TIMEOUT_CYCLES (50),
    .AVG_LOG2       (2),
    .DW             (DW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .one_shot     (one_shot),
    .clr_err      (clr_err),
    .eng_start    (eng_start),
    .eng_ready    (eng_ready),
    .eng_data     (eng_data),
    .sample       (sample),
    .avg          (avg),
    .sample_valid (sample_valid),
    .busy         (busy),
    .timeout_err  (timeout_err),
    .overrun      (overrun),
    .sample_count (sample_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // Engine: accepts 3 cycles after start, completes 10 later.
  initial begin : eng
    int ph;
    int n;
    ph = 0;
    n  = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        ph = 0;
        eng_ready = 1'b1;
      end else begin
        case (ph)
          0: if (eng_start && eng_respond) begin
            ph = 1;
            n  = 0;
          end
          1: begin
            n++;
            if (n == 3) begin
              eng_ready = 1'b0;
              ph = 2;
              n  = 0;
            end
          end
          default: begin
            n++;
            if (n == 10) begin
              eng_data = (data_q.size() > 0)
                       ? data_q.pop_front() : 16'hDEAD;
              eng_ready = 1'b1;
              rise_cyc  = cyc;
              ph = 0;
            end
          end
        endcase
      end
    end
  end

  initial begin : mon
    vec_t e;
    forever begin
      @(negedge clk);
      if (rst && sample_valid) begin
        valid_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_valid: got %0h expected none",
                   sample);
        end else begin
          e = exp_q.pop_front();
          chk("sample", sample, e.data);
          chk("avg", avg, e.avg);
          chk("count", sample_count, e.cnt);
          chk("latency", cyc - rise_cyc, 2);
        end
      end
    end
  end

  task automatic pulse_os();
    @(posedge clk);
    #1 one_shot = 1'b1;
    @(posedge clk);
    #1 one_shot = 1'b0;
  endtask

  task automatic pulse_clr();
    @(posedge clk);
    #1 clr_err = 1'b1;
    @(posedge clk);
    #1 clr_err = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_count(input logic [7:0] n,
                            input int budget);
    int k;
    k = 0;
    while (sample_count !== n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("wait_count", sample_count, n);
  endtask

  task automatic queue_vec(input int i);
    data_q.push_back(vec[i].data);
    exp_q.push_back(vec[i]);
  endtask

  initial begin : main
    int k;
    int n;
    vec[0] = '{16'h0100, 16'h0100, 8'd1};
    vec[1] = '{16'h0200, 16'h0140, 8'd2};
    vec[2] = '{16'h0300, 16'h01C0, 8'd3};
    vec[3] = '{16'h0400, 16'h0280, 8'd4};
    vec[4] = '{16'h0500, 16'h0380, 8'd5};
    vec[5] = '{16'h0600, 16'h0480, 8'd6};
    vec[6] = '{16'h0700, 16'h0580, 8'd7};
    vec[7] = '{16'h0800, 16'h0680, 8'd8};
    vec[8] = '{16'h0900, 16'h0780, 8'd9};
    vec[9] = '{16'h0A00, 16'h0A00, 8'd1};

    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_start", eng_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sample", sample, 0);
    chk("rst_avg", avg, 0);
    chk("rst_valid", sample_valid, 0);
    chk("rst_tmo", timeout_err, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_cnt", sample_count, 0);
    @(negedge clk);
    rst = 1'b1;

    // Periodic sampling, four-deep average rollover.
    for (int i = 0; i < 5; i++) queue_vec(i);
    @(posedge clk);
    #1 enable = 1'b1;
    wait_count(8'd5, 700);
    enable = 1'b0;
    chk("valid_n", valid_cyc.size(), 5);
    for (int i = 1; i < valid_cyc.size(); i++) begin
      chk("period", valid_cyc[i] - valid_cyc[i-1], 100);
    end
    chk("ovr_periodic", overrun, 0);

    // One-shot with periodic sampling off.
    queue_vec(5);
    pulse_os();
    wait_count(8'd6, 100);
    repeat (40) @(negedge clk);
    chk("os_single", sample_count, 6);

    // One-shot in the same cycle as a tick.
    queue_vec(6);
    @(posedge clk);
    #1 enable = 1'b1;
    repeat (99) @(posedge clk);
    #1 one_shot = 1'b1;
    @(posedge clk);
    #1 one_shot = 1'b0;
    enable = 1'b0;
    wait_count(8'd7, 100);
    repeat (40) @(negedge clk);
    chk("tick_os_cnt", sample_count, 7);
    chk("tick_os_ovr", overrun, 0);

    // Two one-shots while busy: one served, one lost.
    queue_vec(7);
    queue_vec(8);
    pulse_os();
    repeat (5) @(posedge clk);
    pulse_os();
    pulse_os();
    @(negedge clk);
    chk("busy_ovr", overrun, 1);
    wait_count(8'd9, 150);
    repeat (40) @(negedge clk);
    chk("busy_cnt", sample_count, 9);
    chk("busy_ovr_held", overrun, 1);
    pulse_clr();
    chk("ovr_clr", overrun, 0);

    // Engine never accepts: ARM times out.
    eng_respond = 1'b0;
    pulse_os();
    k = 0;
    while (!eng_start && k < 10) begin
      @(negedge clk);
      k++;
    end
    n = 0;
    while (eng_start && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("arm_cycles", n, 50);
    chk("tmo_err", timeout_err, 1);
    chk("tmo_start", eng_start, 0);
    chk("tmo_busy", busy, 0);
    chk("tmo_cnt", sample_count, 9);
    chk("tmo_sample", sample, 16'h0900);
    chk("tmo_avg", avg, 16'h0780);
    repeat (10) @(negedge clk);
    chk("tmo_cnt_held", sample_count, 9);
    pulse_clr();
    chk("tmo_clr", timeout_err, 0);
    eng_respond = 1'b1;

    // Reset while waiting for the engine.
    pulse_os();
    k = 0;
    while (eng_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(posedge clk);
    chk("busy_pre_rst", busy, 1);
    #2 rst = 1'b0;
    #1;
    chk("mrst_start", eng_start, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_sample", sample, 0);
    chk("mrst_avg", avg, 0);
    chk("mrst_cnt", sample_count, 0);
    chk("mrst_valid", sample_valid, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // First sample after reset preloads the average.
    queue_vec(9);
    @(posedge clk);
    #1 enable = 1'b1;
    wait_count(8'd1, 200);
    enable = 1'b0;
    repeat (20) @(negedge clk);
    chk("exp_drained", exp_q.size(), 0);
    chk("data_drained", data_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
